stream_upsizer_flushable: RTL and testbench

- Packs Ratio consecutive narrow stream beats of type T into one wide word with a per-slot strobe.
- A last_i beat closes a partial word early; flush_i discards all in-flight state.
- Sits directly upstream of the flushable spill register in the datapath; its wide output feeds that register.
- The spill register cuts the timing paths; this block only assembles words.

---
 rtl/stream_upsizer_pkg.sv | 11 +
 rtl/stream_upsizer_flushable.sv | 96 +++++++++
 tb/tb_stream_upsizer_flushable.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/stream_upsizer_pkg.sv
// Shared types and limits for the stream upsizer.
package stream_upsizer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int MaxRatio = 16;

endpackage

// File: rtl/stream_upsizer_flushable.sv
// Packs Ratio narrow beats into one wide word with per-slot strobes; last_i closes early, flush_i drops all.
// Optional STREAM_UPSIZER_BACK2BACK_EN: accept a new beat in the same cycle the held word leaves.
module stream_upsizer_flushable
  import stream_upsizer_pkg::*;
#(
  parameter type T     = logic [7:0],
  parameter int  Ratio = 4,
  parameter int  IdxW  = $clog2(Ratio)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  T                        data_i,
  input  logic                    last_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [Ratio*$bits(T)-1:0] data_o,
  output logic [Ratio-1:0]        strb_o,
  output logic                    last_o
);

  localparam int TW = $bits(T);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Ratio - 1);

  if (Ratio < 2 || Ratio > MaxRatio) begin : g_bad_ratio
    $error("stream_upsizer_flushable: Ratio must be within 2..%0d", MaxRatio);
  end
  if (IdxW != $clog2(Ratio)) begin : g_bad_idxw
    $error("stream_upsizer_flushable: IdxW is derived and must not be overridden");
  end

  state_e                     state_q;
  logic [IdxW-1:0]            idx_q;
  logic [Ratio-1:0][TW-1:0]   data_q;
  logic [Ratio-1:0]           strb_q;
  logic                       last_q;

  logic accept, xfer;

  assign valid_o = (state_q == HOLD);
`ifdef STREAM_UPSIZER_BACK2BACK_EN
  assign ready_o = !valid_o || ready_i;
`else
  assign ready_o = !valid_o;
`endif

  assign accept = valid_i && ready_o && !flush_i;
  assign xfer   = valid_o && ready_i;

  assign data_o = data_q;
  assign strb_o = strb_q;
  assign last_o = last_q;

  // A transfer clears the word first; a same-cycle beat then overrides slot 0,
  // which is where idx_q always points while holding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
    end else if (flush_i) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      if (xfer) begin
        state_q <= FILL;
        data_q  <= '0;
        strb_q  <= '0;
        last_q  <= 1'b0;
      end
      if (accept) begin
        data_q[idx_q] <= data_i;
        strb_q[idx_q] <= 1'b1;
        if (idx_q == LastIdx || last_i) begin
          state_q <= HOLD;
          last_q  <= last_i;
          idx_q   <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_flush_no_valid: assert property (@(posedge clk_i) disable iff (!rst_ni) flush_i |-> !valid_i);
`endif

endmodule

// File: tb/tb_stream_upsizer_flushable.sv
// Directed plus randomized checks of stream_upsizer_flushable against a word-grouping reference model.
module tb_stream_upsizer_flushable;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0, valid = 1'b0, last = 1'b0, ready = 1'b0;
  logic [7:0]  din = '0;
  logic        ready_o, valid_o, last_o;
  logic [31:0] data_o;
  logic [3:0]  strb_o;

  stream_upsizer_flushable #(.T(logic [7:0]), .Ratio(R)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(ready_o),
    .data_i(din), .last_i(last), .valid_o(valid_o), .ready_i(ready),
    .data_o(data_o), .strb_o(strb_o), .last_o(last_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [3:0] s; logic l; } word_t;

  int    tests = 0, fails = 0, cyc = 0;
  bit    rnd_rdy = 1'b0;
  word_t got[$];
  word_t exp_q[$];
  logic [7:0] cur[$];

  always @(posedge clk) cyc++;

  // Downstream monitor: a word leaves at the next posedge when both sides are high here.
  always @(negedge clk) if (rst_n && valid_o && ready) got.push_back('{data_o, strb_o, last_o});

  always @(posedge clk) if (rnd_rdy) begin #1; ready = 1'($urandom_range(0, 1)); end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: a word is the beats gathered since the last boundary, slot 0 first, zeros above.
  task automatic model_beat(input logic [7:0] d, input logic l);
    word_t w;
    cur.push_back(d);
    if (cur.size() == R || l) begin
      w.d = '0; w.s = '0; w.l = l;
      foreach (cur[k]) begin w.d[k*8 +: 8] = cur[k]; w.s[k] = 1'b1; end
      exp_q.push_back(w);
      cur.delete();
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    valid = 1'b1; din = d; last = l;
    @(negedge clk);
    while (!ready_o && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) check("send_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [31:0] d, input logic [3:0] s, input logic l);
    word_t w;
    check({tag, "_count"}, 32'(got.size() > 0), 32'(1));
    if (got.size() > 0) begin
      w = got.pop_front();
      check({tag, "_data"}, w.d, d);
      check({tag, "_strb"}, 32'(w.s), 32'(s));
      check({tag, "_last"}, 32'(w.l), 32'(l));
    end
  endtask

  initial begin
    int t0, n_exp, b2b;
    logic [31:0] hd;
`ifdef STREAM_UPSIZER_BACK2BACK_EN
    b2b = 1;
`else
    b2b = 0;
`endif
    #2 rst_n = 1'b0;
    #2;
    check("rst_valid", 32'(valid_o), 32'(0));
    check("rst_ready", 32'(ready_o), 32'(1));
    check("rst_data", data_o, 32'h0);
    check("rst_strb", 32'(strb_o), 32'(0));
    check("rst_last", 32'(last_o), 32'(0));
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    // Full words with continuous input
    ready = 1'b1;
    t0 = cyc;
    for (int i = 1; i <= 8; i++) send(8'(i * 8'h11), 1'b0);
    check("full_cycles", 32'(cyc - t0), 32'(b2b ? 8 : 9));
    idle(3);
    check_word("full_w0", 32'h44332211, 4'hF, 1'b0);
    check_word("full_w1", 32'h88776655, 4'hF, 1'b0);
    check("full_extra", 32'(got.size()), 32'(0));

    // Early close, then backpressure on that word
    ready = 1'b0;
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b1);
    check("early_valid", 32'(valid_o), 32'(1));
    check("early_data", data_o, 32'h0000A2A1);
    check("early_strb", 32'(strb_o), 32'(4'h3));
    check("early_last", 32'(last_o), 32'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(valid_o), 32'(1));
      check("bp_data", data_o, 32'h0000A2A1);
      check("bp_strb", 32'(strb_o), 32'(4'h3));
      check("bp_ready", 32'(ready_o), 32'(0));
    end
    @(posedge clk); #1;
    ready = 1'b1;
    send(8'hB1, 1'b1);
    idle(3);
    check_word("bp_w0", 32'h0000A2A1, 4'h3, 1'b1);
    check_word("bp_w1", 32'h000000B1, 4'h1, 1'b1);

    // Flush mid-word
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    flush = 1'b1; idle(1); flush = 1'b0;
    for (int i = 3; i <= 6; i++) send(8'(i), 1'b0);
    idle(3);
    check_word("flush_mid", 32'h06050403, 4'hF, 1'b0);
    check("flush_mid_extra", 32'(got.size()), 32'(0));

    // Flush while holding a word
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(8'hC0 + i), 1'b0);
    check("hold_valid", 32'(valid_o), 32'(1));
    flush = 1'b1; idle(1); flush = 1'b0;
    check("fh_valid", 32'(valid_o), 32'(0));
    check("fh_strb", 32'(strb_o), 32'(0));
    check("fh_data", data_o, 32'h0);
    check("fh_ready", 32'(ready_o), 32'(1));
    check("fh_none", 32'(got.size()), 32'(0));

    // Asynchronous reset while holding
    for (int i = 1; i <= 4; i++) send(8'(8'hD0 + i), 1'b0);
    hd = data_o;
    check("ar_pre", hd, 32'hD4D3D2D1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(valid_o), 32'(0));
    check("ar_data", data_o, 32'h0);
    check("ar_ready", 32'(ready_o), 32'(1));
    @(negedge clk); rst_n = 1'b1;
    idle(2);
    got.delete();

    // Randomized traffic with random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [7:0] d;
      logic       l;
      d = 8'($urandom);
      l = ($urandom_range(0, 4) == 0);
      if (i == 199) l = 1'b1;
      model_beat(d, l);
      send(d, l);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    n_exp = exp_q.size();
    begin
      int n = 0;
      while (got.size() < n_exp && n < 2000) begin n++; @(posedge clk); end
    end
    rnd_rdy = 1'b0;
    idle(1);
    ready = 1'b0;
    check("rnd_count", 32'(got.size()), 32'(n_exp));
    while (exp_q.size() > 0 && got.size() > 0) begin
      word_t e, g;
      e = exp_q.pop_front();
      g = got.pop_front();
      check("rnd_data", g.d, e.d);
      check("rnd_strb", 32'(g.s), 32'(e.s));
      check("rnd_last", 32'(g.l), 32'(e.l));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
